// File: rtl/ddr_cmd_decoder.sv
// DDR4 command/address front end: one-cycle registered decode of the CA pins into a
// one-hot command vector, with per-bank, refresh and CKE power-state legality tracking.

module ddr_bank_trk #(
    parameter int TRCD = 16,
    parameter int TRP  = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic halt,
    input  logic do_act,
    input  logic do_close,
    output logic is_open,
    output logic is_idle
);
    // Loaded with N-1: the opener's own edge counts, so the command N edges later is the first legal one.
    localparam logic [8:0] TRCD_LD = 9'(TRCD - 1);
    localparam logic [8:0] TRP_LD  = 9'(TRP - 1);

    logic [8:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            is_open <= 1'b0;
            cnt     <= '0;
        end else if (!halt) begin
            if (do_act) begin
                is_open <= 1'b1;
                cnt     <= TRCD_LD;
            end else if (do_close && is_open) begin
                is_open <= 1'b0;
                cnt     <= TRP_LD;
            end else if (cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    assign is_idle = (cnt == '0);
endmodule

module ddr_cmd_decoder #(
    parameter int BGWIDTH   = 2,
    parameter int BAWIDTH   = 2,
    parameter int ADDRWIDTH = 17,
    parameter int COLWIDTH  = 10,
    parameter int TRCD      = 16,
    parameter int TRP       = 16,
    parameter int TRFC      = 260
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 halt,
    input  logic                 cke,
    input  logic                 cs_n,
    input  logic                 act_n,
    input  logic                 ras_n_a16,
    input  logic                 cas_n_a15,
    input  logic                 we_n_a14,
    input  logic [BGWIDTH-1:0]   bg_in,
    input  logic [BAWIDTH-1:0]   ba_in,
    input  logic [13:0]          a,
    output logic [18:0]          commands,
    output logic [BGWIDTH:0]     bg,
    output logic [BAWIDTH:0]     ba,
    output logic [ADDRWIDTH-1:0] row,
    output logic [COLWIDTH-1:0]  column,
    output logic [1:0]           pwr_state
);
    localparam int SW = BGWIDTH + BAWIDTH;
    localparam int NB = 1 << SW;
    localparam logic [8:0] TRFC_LD = 9'(TRFC - 1);

    localparam int C_DES = 0, C_NOP = 1, C_ACT = 2, C_RD = 3, C_RDA = 4, C_WR = 5, C_WRA = 6;
    localparam int C_PRE = 7, C_PREA = 8, C_REF = 9, C_SRE = 10, C_SRX = 11, C_MRS = 12;
    localparam int C_ZQCL = 13, C_ZQCS = 14, C_PDE = 15, C_PDX = 16, C_BC4 = 17, C_ILL = 18;

    typedef enum logic [1:0] {
        PS_ACTIVE = 2'd0,
        PS_PDN    = 2'd1,
        PS_SREF   = 2'd2
    } pwr_t;

    pwr_t          pwr_q, pwr_nxt;
    logic          cke_prev;
    logic [1:0]    mr0_bl;
    logic [8:0]    ref_cnt;
    logic [18:0]   cmd_nxt;
    logic          upd_addr, upd_row, mr_wr, ref_ld;
    logic [NB-1:0] act_vec, close_vec, bank_open, bank_idle;
    logic [SW-1:0] sel;
    logic [2:0]    rcw;
    logic          ref_busy, sel_open, sel_idle, bc4;

    assign sel      = {bg_in, ba_in};
    assign rcw      = {ras_n_a16, cas_n_a15, we_n_a14};
    assign ref_busy = (ref_cnt != '0);
    assign sel_open = bank_open[sel];
    assign sel_idle = bank_idle[sel];
    // Only the burst-length field of MR0 influences decode.
    assign bc4      = (mr0_bl == 2'b10) || ((mr0_bl == 2'b01) && !a[12]);

    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_bank
            ddr_bank_trk #(.TRCD(TRCD), .TRP(TRP)) u_bank (
                .clk      (clk),
                .reset    (reset),
                .halt     (halt),
                .do_act   (act_vec[gi]),
                .do_close (close_vec[gi]),
                .is_open  (bank_open[gi]),
                .is_idle  (bank_idle[gi])
            );
        end
    endgenerate

    always_comb begin
        cmd_nxt   = '0;
        pwr_nxt   = pwr_q;
        upd_addr  = 1'b0;
        upd_row   = 1'b0;
        mr_wr     = 1'b0;
        ref_ld    = 1'b0;
        act_vec   = '0;
        close_vec = '0;
        case (pwr_q)
            PS_ACTIVE: begin
                if (cke) begin
                    if (cs_n) begin
                        cmd_nxt[C_DES] = 1'b1;
                    end else if (!act_n) begin
                        if (ref_busy || sel_open || !sel_idle) cmd_nxt[C_ILL] = 1'b1;
                        else begin
                            cmd_nxt[C_ACT] = 1'b1;
                            act_vec[sel]   = 1'b1;
                            upd_addr       = 1'b1;
                            upd_row        = 1'b1;
                        end
                    end else begin
                        case (rcw)
                            3'b000: begin
                                if (ref_busy) cmd_nxt[C_ILL] = 1'b1;
                                else begin
                                    cmd_nxt[C_MRS] = 1'b1;
                                    upd_addr       = 1'b1;
                                    mr_wr          = (sel == '0);
                                end
                            end
                            3'b001: begin
                                if (ref_busy || (|bank_open) || !(&bank_idle)) cmd_nxt[C_ILL] = 1'b1;
                                else begin
                                    cmd_nxt[C_REF] = 1'b1;
                                    ref_ld         = 1'b1;
                                    upd_addr       = 1'b1;
                                end
                            end
                            3'b010: begin
                                if (ref_busy) cmd_nxt[C_ILL] = 1'b1;
                                else begin
                                    upd_addr = 1'b1;
                                    if (a[10]) begin
                                        cmd_nxt[C_PREA] = 1'b1;
                                        close_vec       = '1;
                                    end else begin
                                        cmd_nxt[C_PRE] = 1'b1;
                                        close_vec[sel] = 1'b1;
                                    end
                                end
                            end
                            3'b100, 3'b101: begin
                                if (ref_busy || !sel_open || !sel_idle) cmd_nxt[C_ILL] = 1'b1;
                                else begin
                                    upd_addr       = 1'b1;
                                    cmd_nxt[C_BC4] = bc4;
                                    if (rcw[0]) begin
                                        if (a[10]) cmd_nxt[C_RDA] = 1'b1;
                                        else       cmd_nxt[C_RD]  = 1'b1;
                                    end else begin
                                        if (a[10]) cmd_nxt[C_WRA] = 1'b1;
                                        else       cmd_nxt[C_WR]  = 1'b1;
                                    end
                                    close_vec[sel] = a[10];
                                end
                            end
                            3'b110: begin
                                if (ref_busy) cmd_nxt[C_ILL] = 1'b1;
                                else begin
                                    upd_addr = 1'b1;
                                    if (a[10]) cmd_nxt[C_ZQCL] = 1'b1;
                                    else       cmd_nxt[C_ZQCS] = 1'b1;
                                end
                            end
                            3'b111: begin
                                cmd_nxt[C_NOP] = 1'b1;
                                upd_addr       = 1'b1;
                            end
                            default: cmd_nxt[C_ILL] = 1'b1;
                        endcase
                    end
                end else if (cke_prev) begin
                    // Falling CKE: only DES/NOP (power-down) or REF (self-refresh) may ride on it.
                    if (cs_n || (act_n && rcw == 3'b111)) begin
                        cmd_nxt[C_PDE] = 1'b1;
                        pwr_nxt        = PS_PDN;
                    end else if (act_n && rcw == 3'b001 && !(|bank_open)) begin
                        cmd_nxt[C_SRE] = 1'b1;
                        pwr_nxt        = PS_SREF;
                    end else begin
                        cmd_nxt[C_ILL] = 1'b1;
                    end
                end
            end
            PS_PDN: begin
                if (cke) begin
                    cmd_nxt[C_PDX] = 1'b1;
                    pwr_nxt        = PS_ACTIVE;
                end
            end
            PS_SREF: begin
                if (cke) begin
                    cmd_nxt[C_SRX] = 1'b1;
                    pwr_nxt        = PS_ACTIVE;
                end
            end
            default: pwr_nxt = PS_ACTIVE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            commands <= '0;
            bg       <= '0;
            ba       <= '0;
            row      <= '0;
            column   <= '0;
            pwr_q    <= PS_ACTIVE;
            cke_prev <= 1'b1;
            mr0_bl   <= 2'b00;
            ref_cnt  <= '0;
        end else if (!halt) begin
            commands <= cmd_nxt;
            pwr_q    <= pwr_nxt;
            cke_prev <= cke;
            if (upd_addr) begin
                bg     <= {1'b0, bg_in};
                ba     <= {1'b0, ba_in};
                column <= a[COLWIDTH-1:0];
            end
            if (upd_row) row <= {ras_n_a16, cas_n_a15, we_n_a14, a};
            if (mr_wr) mr0_bl <= a[1:0];
            if (ref_ld)        ref_cnt <= TRFC_LD;
            else if (ref_busy) ref_cnt <= ref_cnt - 1'b1;
        end
    end

    assign pwr_state = pwr_q;
endmodule

// File: tb/tb_ddr_cmd_decoder.sv
// Directed bench for ddr_cmd_decoder: a decode table plus timing/power/halt/reset sequences.

module tb_ddr_cmd_decoder;
    logic        clk = 1'b0;
    logic        reset, halt, cke, cs_n, act_n, ras_n_a16, cas_n_a15, we_n_a14;
    logic [1:0]  bg_in, ba_in;
    logic [13:0] a;
    logic [18:0] commands;
    logic [2:0]  bg, ba;
    logic [16:0] row;
    logic [9:0]  column;
    logic [1:0]  pwr_state;

    int checks   = 0;
    int failures = 0;

    localparam logic [18:0] DES  = 19'h00001, NOP  = 19'h00002, ACT  = 19'h00004, RD   = 19'h00008;
    localparam logic [18:0] RDA  = 19'h00010, PRE  = 19'h00080, PREA = 19'h00100, REF  = 19'h00200;
    localparam logic [18:0] SRE  = 19'h00400, SRX  = 19'h00800, MRS  = 19'h01000, ZQCL = 19'h02000;
    localparam logic [18:0] ZQCS = 19'h04000, PDE  = 19'h08000, PDX  = 19'h10000, BC4  = 19'h20000;
    localparam logic [18:0] ILL  = 19'h40000;

    always #5 clk = ~clk;

    ddr_cmd_decoder dut (
        .clk(clk), .reset(reset), .halt(halt), .cke(cke), .cs_n(cs_n), .act_n(act_n),
        .ras_n_a16(ras_n_a16), .cas_n_a15(cas_n_a15), .we_n_a14(we_n_a14),
        .bg_in(bg_in), .ba_in(ba_in), .a(a), .commands(commands), .bg(bg), .ba(ba),
        .row(row), .column(column), .pwr_state(pwr_state)
    );

    typedef struct {
        logic        cke, cs_n, act_n;
        logic [2:0]  rcw;
        logic [1:0]  bgi, bai;
        logic [13:0] ai;
        logic [18:0] cmd;
        logic [1:0]  pwr;
        logic        chk;
        logic [2:0]  ebg, eba;
        logic [9:0]  ecol;
    } vec_t;

    vec_t tbl[18];

    function automatic vec_t mk(input logic ck, input logic cs, input logic an, input logic [2:0] r,
                                input logic [1:0] g, input logic [1:0] b, input logic [13:0] av,
                                input logic [18:0] ec, input logic [1:0] ep, input logic ch,
                                input logic [2:0] eg, input logic [2:0] eb, input logic [9:0] ecl);
        vec_t v;
        v.cke = ck; v.cs_n = cs; v.act_n = an; v.rcw = r; v.bgi = g; v.bai = b; v.ai = av;
        v.cmd = ec; v.pwr = ep; v.chk = ch; v.ebg = eg; v.eba = eb; v.ecol = ecl;
        return v;
    endfunction

    task automatic pins(input logic ck, input logic cs, input logic an, input logic [2:0] r,
                        input logic [1:0] g, input logic [1:0] b, input logic [13:0] av);
        cke = ck; cs_n = cs; act_n = an; {ras_n_a16, cas_n_a15, we_n_a14} = r;
        bg_in = g; ba_in = b; a = av;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cmd(input string nm, input logic [18:0] exp);
        checks++;
        if (commands !== exp) begin
            failures++;
            $display("FAIL %s commands: got 0x%05h expected 0x%05h", nm, commands, exp);
        end
    endtask

    task automatic chk_pwr(input string nm, input logic [1:0] exp);
        checks++;
        if (pwr_state !== exp) begin
            failures++;
            $display("FAIL %s pwr_state: got %0d expected %0d", nm, pwr_state, exp);
        end
    endtask

    task automatic chk_addr(input string nm, input logic [2:0] eg, input logic [2:0] eb, input logic [9:0] ec);
        checks++;
        if (bg !== eg || ba !== eb || column !== ec) begin
            failures++;
            $display("FAIL %s addr: got bg=%0d ba=%0d col=0x%03h expected bg=%0d ba=%0d col=0x%03h",
                     nm, bg, ba, column, eg, eb, ec);
        end
    endtask

    task automatic chk_row(input string nm, input logic [16:0] exp);
        checks++;
        if (row !== exp) begin
            failures++;
            $display("FAIL %s row: got 0x%05h expected 0x%05h", nm, row, exp);
        end
    endtask

    task automatic des(input int n);
        repeat (n) begin
            pins(1'b1, 1'b1, 1'b1, 3'b111, 2'd0, 2'd0, 14'h0);
            cyc();
        end
    endtask

    task automatic act_cmd(input logic [1:0] g, input logic [1:0] b, input logic [16:0] r);
        pins(1'b1, 1'b0, 1'b0, r[16:14], g, b, r[13:0]);
    endtask

    task automatic cmd(input logic [2:0] r, input logic [1:0] g, input logic [1:0] b, input logic [13:0] av);
        pins(1'b1, 1'b0, 1'b1, r, g, b, av);
    endtask

    initial begin
        tbl[0]  = mk(1'b1, 1'b1, 1'b1, 3'b111, 2'd0, 2'd0, 14'h0000, DES,   2'd0, 1'b1, 3'd0, 3'd0, 10'h000);
        tbl[1]  = mk(1'b1, 1'b0, 1'b1, 3'b111, 2'd1, 2'd1, 14'h03FF, NOP,   2'd0, 1'b1, 3'd1, 3'd1, 10'h3FF);
        tbl[2]  = mk(1'b1, 1'b0, 1'b1, 3'b000, 2'd0, 2'd0, 14'h0000, MRS,   2'd0, 1'b1, 3'd0, 3'd0, 10'h000);
        tbl[3]  = mk(1'b1, 1'b0, 1'b1, 3'b110, 2'd0, 2'd0, 14'h0400, ZQCL,  2'd0, 1'b1, 3'd0, 3'd0, 10'h000);
        tbl[4]  = mk(1'b1, 1'b0, 1'b1, 3'b110, 2'd2, 2'd3, 14'h00AA, ZQCS,  2'd0, 1'b1, 3'd2, 3'd3, 10'h0AA);
        tbl[5]  = mk(1'b1, 1'b0, 1'b1, 3'b011, 2'd1, 2'd1, 14'h0111, ILL,   2'd0, 1'b1, 3'd2, 3'd3, 10'h0AA);
        tbl[6]  = mk(1'b1, 1'b0, 1'b1, 3'b101, 2'd0, 2'd0, 14'h0055, ILL,   2'd0, 1'b1, 3'd2, 3'd3, 10'h0AA);
        tbl[7]  = mk(1'b1, 1'b0, 1'b1, 3'b010, 2'd3, 2'd3, 14'h0005, PRE,   2'd0, 1'b1, 3'd3, 3'd3, 10'h005);
        tbl[8]  = mk(1'b1, 1'b0, 1'b0, 3'b111, 2'd2, 2'd1, 14'h0012, ACT,   2'd0, 1'b1, 3'd2, 3'd1, 10'h012);
        tbl[9]  = mk(1'b1, 1'b0, 1'b0, 3'b111, 2'd2, 2'd1, 14'h0034, ILL,   2'd0, 1'b1, 3'd2, 3'd1, 10'h012);
        tbl[10] = mk(1'b1, 1'b0, 1'b1, 3'b010, 2'd0, 2'd0, 14'h0400, PREA,  2'd0, 1'b1, 3'd0, 3'd0, 10'h000);
        tbl[11] = mk(1'b1, 1'b0, 1'b0, 3'b111, 2'd2, 2'd1, 14'h0012, ILL,   2'd0, 1'b0, 3'd0, 3'd0, 10'h000);
        tbl[12] = mk(1'b1, 1'b0, 1'b1, 3'b100, 2'd2, 2'd1, 14'h0000, ILL,   2'd0, 1'b0, 3'd0, 3'd0, 10'h000);
        tbl[13] = mk(1'b0, 1'b1, 1'b1, 3'b111, 2'd0, 2'd0, 14'h0000, PDE,   2'd1, 1'b0, 3'd0, 3'd0, 10'h000);
        tbl[14] = mk(1'b0, 1'b0, 1'b1, 3'b101, 2'd1, 2'd1, 14'h0155, 19'h0, 2'd1, 1'b1, 3'd0, 3'd0, 10'h000);
        tbl[15] = mk(1'b1, 1'b0, 1'b1, 3'b111, 2'd1, 2'd1, 14'h0011, PDX,   2'd0, 1'b1, 3'd0, 3'd0, 10'h000);
        tbl[16] = mk(1'b0, 1'b0, 1'b0, 3'b111, 2'd0, 2'd0, 14'h0000, ILL,   2'd0, 1'b0, 3'd0, 3'd0, 10'h000);
        tbl[17] = mk(1'b1, 1'b0, 1'b1, 3'b111, 2'd1, 2'd0, 14'h0003, NOP,   2'd0, 1'b1, 3'd1, 3'd0, 10'h003);

        // Reset held three cycles, then release.
        halt = 1'b0;
        reset = 1'b1;
        pins(1'b1, 1'b1, 1'b1, 3'b111, 2'd0, 2'd0, 14'h0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk_cmd($sformatf("reset%0d", i), 19'h0);
        end
        chk_pwr("reset", 2'd0);
        chk_addr("reset", 3'd0, 3'd0, 10'h0);
        chk_row("reset", 17'h0);
        reset = 1'b0;
        cyc();
        chk_cmd("post_reset_des", DES);

        for (int i = 0; i < 18; i++) begin
            pins(tbl[i].cke, tbl[i].cs_n, tbl[i].act_n, tbl[i].rcw, tbl[i].bgi, tbl[i].bai, tbl[i].ai);
            cyc();
            chk_cmd($sformatf("tbl%0d", i), tbl[i].cmd);
            chk_pwr($sformatf("tbl%0d", i), tbl[i].pwr);
            if (tbl[i].chk) chk_addr($sformatf("tbl%0d", i), tbl[i].ebg, tbl[i].eba, tbl[i].ecol);
        end

        // tRCD: RD at +5 and +15 illegal, at +16 legal.
        act_cmd(2'd1, 2'd2, 17'h1ABCD); cyc();
        chk_cmd("trcd_act", ACT);
        chk_row("trcd_act", 17'h1ABCD);
        chk_addr("trcd_act", 3'd1, 3'd2, 10'h3CD);
        des(4);
        cmd(3'b101, 2'd1, 2'd2, 14'h0155); cyc();
        chk_cmd("trcd_rd_p5", ILL);
        chk_addr("trcd_rd_p5", 3'd1, 3'd2, 10'h3CD);
        des(9);
        cmd(3'b101, 2'd1, 2'd2, 14'h0155); cyc();
        chk_cmd("trcd_rd_p15", ILL);
        cmd(3'b101, 2'd1, 2'd2, 14'h0155); cyc();
        chk_cmd("trcd_rd_p16", RD);
        chk_addr("trcd_rd_p16", 3'd1, 3'd2, 10'h155);

        // MR0 burst mode and BC4 flag.
        cmd(3'b000, 2'd0, 2'd0, 14'h0001); cyc(); chk_cmd("mr0_otf", MRS);
        cmd(3'b101, 2'd1, 2'd2, 14'h0155); cyc(); chk_cmd("otf_a12lo", RD | BC4);
        cmd(3'b101, 2'd1, 2'd2, 14'h1155); cyc(); chk_cmd("otf_a12hi", RD);
        cmd(3'b000, 2'd0, 2'd0, 14'h0002); cyc(); chk_cmd("mr0_fix", MRS);
        cmd(3'b101, 2'd1, 2'd2, 14'h1155); cyc(); chk_cmd("fix_a12hi", RD | BC4);
        cmd(3'b000, 2'd1, 2'd0, 14'h0000); cyc(); chk_cmd("mr4_write", MRS);
        cmd(3'b101, 2'd1, 2'd2, 14'h1155); cyc(); chk_cmd("mr4_not_stored", RD | BC4);
        cmd(3'b000, 2'd0, 2'd0, 14'h0000); cyc(); chk_cmd("mr0_clr", MRS);
        cmd(3'b101, 2'd1, 2'd2, 14'h0155); cyc(); chk_cmd("bl8_rd", RD);
        cmd(3'b101, 2'd1, 2'd2, 14'h0555); cyc(); chk_cmd("rda", RDA);
        act_cmd(2'd1, 2'd2, 17'h00001); cyc(); chk_cmd("act_after_rda", ILL);

        // tRFC window, then PRE to a closed bank.
        des(16);
        cmd(3'b001, 2'd0, 2'd0, 14'h0000); cyc(); chk_cmd("ref", REF);
        des(98);
        cmd(3'b111, 2'd0, 2'd0, 14'h0000); cyc(); chk_cmd("nop_in_trfc", NOP);
        act_cmd(2'd0, 2'd0, 17'h00042); cyc(); chk_cmd("act_p100", ILL);
        des(158);
        act_cmd(2'd0, 2'd0, 17'h00042); cyc(); chk_cmd("act_p259", ILL);
        act_cmd(2'd0, 2'd0, 17'h00042); cyc(); chk_cmd("act_p260", ACT);
        chk_row("act_p260", 17'h00042);
        cmd(3'b010, 2'd3, 2'd3, 14'h0000); cyc(); chk_cmd("pre_closed", PRE);
        act_cmd(2'd3, 2'd3, 17'h00007); cyc(); chk_cmd("act_after_pre_closed", ACT);
        cmd(3'b001, 2'd0, 2'd0, 14'h0000); cyc(); chk_cmd("ref_banks_open", ILL);

        // Self-refresh entry and exit.
        cmd(3'b010, 2'd0, 2'd0, 14'h0400); cyc(); chk_cmd("prea", PREA);
        des(16);
        pins(1'b0, 1'b0, 1'b1, 3'b001, 2'd0, 2'd0, 14'h0); cyc();
        chk_cmd("sre", SRE);
        chk_pwr("sre", 2'd2);
        for (int i = 0; i < 3; i++) begin
            pins(1'b0, 1'b0, 1'b1, 3'b101, 2'd0, 2'd0, 14'h0); cyc();
            chk_cmd($sformatf("sref_hold%0d", i), 19'h0);
        end
        chk_pwr("sref_hold", 2'd2);
        cmd(3'b111, 2'd0, 2'd0, 14'h0000); cyc();
        chk_cmd("srx", SRX);
        chk_pwr("srx", 2'd0);
        cmd(3'b111, 2'd0, 2'd0, 14'h0000); cyc(); chk_cmd("nop_after_srx", NOP);

        // halt during a tRCD countdown freezes counters and outputs.
        act_cmd(2'd0, 2'd1, 17'h00000); cyc(); chk_cmd("halt_act", ACT);
        des(5);
        halt = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cmd(3'b101, 2'd0, 2'd1, 14'h0155); cyc();
            chk_cmd($sformatf("halt%0d", i), DES);
        end
        chk_addr("halt", 3'd0, 3'd1, 10'h000);
        halt = 1'b0;
        des(9);
        cmd(3'b101, 2'd0, 2'd1, 14'h0155); cyc(); chk_cmd("halt_rd_p25", ILL);
        cmd(3'b101, 2'd0, 2'd1, 14'h0155); cyc(); chk_cmd("halt_rd_p26", RD);

        // Reset mid-operation wins over halt and clears bank state.
        act_cmd(2'd2, 2'd2, 17'h00100); cyc(); chk_cmd("pre_rst_act", ACT);
        reset = 1'b1;
        halt  = 1'b1;
        cmd(3'b101, 2'd2, 2'd2, 14'h0000); cyc();
        chk_cmd("mid_reset", 19'h0);
        chk_addr("mid_reset", 3'd0, 3'd0, 10'h0);
        chk_row("mid_reset", 17'h0);
        reset = 1'b0;
        halt  = 1'b0;
        cmd(3'b101, 2'd2, 2'd2, 14'h0000); cyc(); chk_cmd("rd_after_reset", ILL);
        act_cmd(2'd2, 2'd2, 17'h00100); cyc(); chk_cmd("act_after_reset", ACT);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ddr_cmd_decoder.md
Name: ddr_cmd_decoder

Overview:
- Front-end stage directly upstream of the per-device chip model.
- Samples raw DDR4 command/address pins each clock and decodes them into the 19-bit one-hot command vector, bank group, bank, row and column that the chip model consumes.
- Tracks CKE power states, the MR0 burst mode, per-bank open/busy state and basic timing (tRCD, tRP, tRFC).
- Flags protocol violations instead of forwarding them.

Parameters:
- BGWIDTH, 2, bank-group address bits.
- BAWIDTH, 2, bank address bits.
- ADDRWIDTH, 17, row address bits. Must be 17: row = {ras_n_a16, cas_n_a15, we_n_a14, a[13:0]}.
- COLWIDTH, 10, column bits, taken from a[COLWIDTH-1:0].
- TRCD, 16, cycles from ACT until RD/WR is legal to that bank.
- TRP, 16, cycles from PRE until ACT is legal to that bank.
- TRFC, 260, cycles from REF until any command other than DES/NOP is legal.

Ports:
- clk  in  1  Single clock. One clock; all state updates on its rising edge.
- reset  in  1  Synchronous, active-high reset.
- halt  in  1  When high: all state frozen, outputs held.
- cke  in  1  Clock enable pin.
- cs_n  in  1  Chip select, active low.
- act_n  in  1  Activate, active low.
- ras_n_a16  in  1  RAS_n / A16.
- cas_n_a15  in  1  CAS_n / A15.
- we_n_a14  in  1  WE_n / A14.
- bg_in  in  BGWIDTH  Bank group pins.
- ba_in  in  BAWIDTH  Bank pins.
- a  in  14  A13..A0. A10 = AP/all-banks; A12 = BC_n.
- commands  out  19  One-hot decoded command.
- bg  out  BGWIDTH+1  Registered bank group, zero-extended.
- ba  out  BAWIDTH+1  Registered bank, zero-extended.
- row  out  ADDRWIDTH  Registered row address.
- column  out  COLWIDTH  Registered column address.
- pwr_state  out  2  Power state: 0 ACTIVE, 1 POWERDOWN, 2 SELFREF.

Behaviour:
- Command bit index map:
  - 0 DES, 1 NOP, 2 ACT, 3 RD, 4 RDA, 5 WR, 6 WRA, 7 PRE, 8 PREA, 9 REF, 10 SRE, 11 SRX, 12 MRS, 13 ZQCL, 14 ZQCS, 15 PDE, 16 PDX.
  - 17 BC4: asserted together with 3/4/5/6.
  - 18 ILLEGAL: asserted alone.
- Latency: exactly 1 cycle. Pins sampled at edge N appear on all outputs after edge N. All outputs are registered.
- Reset: commands = 0, bg/ba/row/column = 0, pwr_state = ACTIVE, cke_prev = 1, all banks closed and not busy, busy counters = 0, MR0 = 0, refresh counter = 0.
- Decode in ACTIVE state with cke_prev = 1 and cke = 1:
  - cs_n = 1 -> DES.
  - act_n = 0 -> ACT; row from pins.
  - Otherwise decode {ras, cas, we}:
    - 000 MRS
    - 001 REF
    - 010 PRE if A10 = 0, PREA if A10 = 1
    - 011 ILLEGAL (RFU)
    - 100 WR / WRA (by A10)
    - 101 RD / RDA (by A10)
    - 110 ZQCL if A10 = 1, ZQCS if A10 = 0
    - 111 NOP
  - column = a[COLWIDTH-1:0].
  - row updates only on ACT; bg/ba update on every non-DES decode.
- BC4 is asserted when MR0[1:0] = 01 (on-the-fly) and A12 = 0 on RD/RDA/WR/WRA. For MR0[1:0] = 10 (fixed BC4), BC4 is always asserted on those commands.
- MRS with {bg_in, ba_in} = 0 loads MR0 from a[13:0]. Other MR indices are accepted but not stored.
- CKE and power-state machine:
  - ACTIVE, cke 1->0:
    - with DES/NOP -> PDE, go to POWERDOWN.
    - with REF and all banks closed -> SRE, go to SELFREF.
    - with any other command -> ILLEGAL, stay in ACTIVE.
  - POWERDOWN / SELFREF, cke stays 0: output commands = 0 and ignore pins.
  - POWERDOWN, cke 0->1 -> PDX, go to ACTIVE.
  - SELFREF, cke 0->1 -> SRX, go to ACTIVE.
- Bank tracking (2^(BGWIDTH+BAWIDTH) banks, each with an open bit and a 9-bit down-counter):
  - ACT: legal only if the bank is closed and its counter = 0. Sets open, loads TRCD.
  - RD/WR: legal only if the bank is open and its counter = 0. RDA/WRA additionally close the bank and load TRP.
  - PRE: closes the bank and loads TRP. PRE to an already-closed bank is legal (no-op, counter untouched).
  - PREA: closes all banks and loads TRP into each open bank.
  - REF: legal only if all banks are closed and all counters = 0. Loads the refresh counter with TRFC. While the refresh counter != 0, anything except DES/NOP is ILLEGAL.
  - Counters decrement by 1 per non-halted cycle and saturate at 0.
- An illegal command outputs only bit 18, changes no bank or MR state, and leaves bg/ba/row/column unchanged.
- Simultaneous counter expiry and a command to the same bank on the same edge: the command sees counter = 0 only if the counter read 0 before the edge. No bypass.
- halt high: no state changes, outputs hold their values. halt takes precedence over decode; reset takes precedence over halt.
- Reset mid-operation (including during SELFREF or a counter run) returns everything to reset values on the next edge.

Test Plan:
- Reset asserted 3 cycles, then cs_n = 1 -> commands = 0 during reset; commands = 19'h00001 (DES) one cycle after release.
- ACT bg = 1, ba = 2, row = 17'h1ABCD; RD col 10'h155 issued 5 cycles later -> ACT bit 2 with row 17'h1ABCD, then ILLEGAL (tRCD). Same RD issued at +16 -> bit 3 with column 10'h155.
- MR0 written = 14'h0001, then RD with A12 = 0 -> commands = bit 3 | bit 17. With A12 = 1 -> bit 3 only.
- All banks idle, REF with cke 1->0 -> SRE, pwr_state = 2, commands = 0 while cke low; cke 0->1 with NOP -> SRX, pwr_state = 0.
- REF then ACT 100 cycles later -> ILLEGAL. ACT at +260 -> legal ACT. PRE to a closed bank -> PRE, no state change.
- halt held 10 cycles during the tRCD countdown -> counter frozen, outputs unchanged, RD still ILLEGAL until 16 unhalted cycles have elapsed.
